// File: rtl/uart_hello_check_if.sv
// Byte-stream input and message-check result bundle for uart_hello_check.
// Latency: none (wires only).
// Backpressure: none; rx_valid is a one-cycle strobe that cannot be stalled.
// Ports: rx_data/rx_valid (received byte), msg_ok/msg_err (result pulses),
//        busy (message in progress), ok_count/err_count/drop_count (stats).
interface uart_hello_check_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        msg_ok;
    logic        msg_err;
    logic        busy;
    logic [15:0] ok_count;
    logic [7:0]  err_count;
    logic [7:0]  drop_count;

    // Byte source plus result observer.
    modport master (
        output rx_data, rx_valid,
        input  msg_ok, msg_err, busy, ok_count, err_count, drop_count
    );

    // The checker itself.
    modport slave (
        input  rx_data, rx_valid,
        output msg_ok, msg_err, busy, ok_count, err_count, drop_count
    );
endinterface

// File: rtl/uart_hello_check.sv
// Matches a received byte stream against the fixed message "Hello World!\n".
// Latency: msg_ok/msg_err pulse one cycle after the deciding byte or timer expiry.
// Backpressure: none; every rx_valid strobe is consumed, back-to-back included.
// Ports: CLK, reset (async active-high); bus.slave carries rx_data/rx_valid in
//        and msg_ok/msg_err/busy/ok_count/err_count/drop_count out.
module uart_hello_check #(
    parameter int MSG_LEN = 13,
    parameter int TIMEOUT = 1024
) (
    input  logic              CLK,
    input  logic              reset,
    uart_hello_check_if.slave bus
);

    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(MSG_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_EXPIRE = TMR_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, RECV} state_t;

    // Message ROM; indices past the string read as 0x00.
    function automatic logic [7:0] rom_byte(input logic [IDX_W-1:0] i);
        logic [7:0] b;
        case (int'(i))
            0:       b = 8'h48;
            1:       b = 8'h65;
            2:       b = 8'h6C;
            3:       b = 8'h6C;
            4:       b = 8'h6F;
            5:       b = 8'h20;
            6:       b = 8'h57;
            7:       b = 8'h6F;
            8:       b = 8'h72;
            9:       b = 8'h6C;
            10:      b = 8'h64;
            11:      b = 8'h21;
            12:      b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             msg_ok_q, msg_ok_d;
    logic             msg_err_q, msg_err_d;
    logic [15:0]      ok_cnt_q, ok_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic byte_is_first;
    logic byte_is_expected;

    assign byte_is_first    = (bus.rx_data == rom_byte(IDX_W'(0)));
    assign byte_is_expected = (bus.rx_data == rom_byte(idx_q));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tmr_d      = tmr_q;
        msg_ok_d   = 1'b0;
        msg_err_d  = 1'b0;
        ok_cnt_d   = ok_cnt_q;
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (byte_is_first) begin
                        if (MSG_LEN == 1) begin
                            // Single-byte message completes straight from IDLE.
                            msg_ok_d = 1'b1;
                            if (~&ok_cnt_q) ok_cnt_d = ok_cnt_q + 16'd1;
                        end else begin
                            state_d = RECV;
                            idx_d   = IDX_W'(1);
                            tmr_d   = '0;
                        end
                    end else if (~&drop_cnt_q) begin
                        drop_cnt_d = drop_cnt_q + 8'd1;
                    end
                end
            end

            RECV: begin
                // A byte always wins over timer expiry on the same cycle.
                if (bus.rx_valid) begin
                    tmr_d = '0;
                    if (byte_is_expected) begin
                        if (idx_q == LAST_IDX) begin
                            msg_ok_d = 1'b1;
                            if (~&ok_cnt_q) ok_cnt_d = ok_cnt_q + 16'd1;
                            state_d = IDLE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        msg_err_d = 1'b1;
                        if (~&err_cnt_q) err_cnt_d = err_cnt_q + 8'd1;
                        // A stray 'H' is treated as the start of a new message.
                        if (byte_is_first) begin
                            idx_d = IDX_W'(1);
                        end else begin
                            state_d = IDLE;
                            idx_d   = '0;
                        end
                    end
                end else if (tmr_q == TMR_EXPIRE) begin
                    msg_err_d = 1'b1;
                    if (~&err_cnt_q) err_cnt_d = err_cnt_q + 8'd1;
                    state_d = IDLE;
                    idx_d   = '0;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = '0;
                tmr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            tmr_q      <= '0;
            msg_ok_q   <= 1'b0;
            msg_err_q  <= 1'b0;
            ok_cnt_q   <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tmr_q      <= tmr_d;
            msg_ok_q   <= msg_ok_d;
            msg_err_q  <= msg_err_d;
            ok_cnt_q   <= ok_cnt_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.msg_ok     = msg_ok_q;
    assign bus.msg_err    = msg_err_q;
    assign bus.busy       = (state_q == RECV);
    assign bus.ok_count   = ok_cnt_q;
    assign bus.err_count  = err_cnt_q;
    assign bus.drop_count = drop_cnt_q;

endmodule

// File: tb/tb_uart_hello_check.sv
// Directed bench for uart_hello_check with a pulse scoreboard.
// Stimulus pushes the expected pulse kind and edge number; a negedge monitor pops and compares.
// Counter and busy values are compared against a bench-side model after each scenario.
module tb_uart_hello_check;

    localparam int TO = 16;

    localparam int RES_NONE = 0;
    localparam int RES_OK   = 1;
    localparam int RES_ERR  = 2;
    localparam int RES_DROP = 3;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_ok = 0;
    int   exp_err = 0;
    int   exp_drop = 0;
    exp_t q[$];

    logic [7:0] hello [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                               8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

    uart_hello_check_if u_if();

    uart_hello_check #(.MSG_LEN(13), .TIMEOUT(TO)) u_dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every pulse must match the head of the queue.
    always @(negedge CLK) begin
        if (!reset) begin
            if (u_if.msg_ok && u_if.msg_err) begin
                n_tests++;
                n_fail++;
                $display("FAIL pulse_overlap: msg_ok and msg_err both high at edge %0d", cyc);
            end else if (u_if.msg_ok || u_if.msg_err) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: ok=%0b err=%0b at edge %0d, none expected",
                             u_if.msg_ok, u_if.msg_err, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("pulse_kind", u_if.msg_ok ? RES_OK : RES_ERR, e.kind);
                    check("pulse_edge", cyc, e.cyc);
                end
            end
        end
    end

    task automatic note_result(input int res, input int at_cyc);
        case (res)
            RES_OK: begin
                q.push_back('{RES_OK, at_cyc});
                if (exp_ok < 65535) exp_ok++;
            end
            RES_ERR: begin
                q.push_back('{RES_ERR, at_cyc});
                if (exp_err < 255) exp_err++;
            end
            RES_DROP: begin
                if (exp_drop < 255) exp_drop++;
            end
            default: ;
        endcase
    endtask

    // One byte on the next edge; returns #1 after the edge that is gap cycles later.
    task automatic send(input logic [7:0] b, input int res, input int gap);
        @(negedge CLK);
        u_if.rx_data  = b;
        u_if.rx_valid = 1'b1;
        @(posedge CLK);
        #1;
        u_if.rx_valid = 1'b0;
        note_result(res, cyc);
        if (gap > 1) begin
            repeat (gap - 1) @(posedge CLK);
            #1;
        end
    endtask

    // Rest of the message from index 'from', last byte completes it.
    task automatic send_msg(input int from, input int gap);
        for (int i = from; i < 13; i++)
            send(hello[i], (i == 12) ? RES_OK : RES_NONE, gap);
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_ok_count"},   int'(u_if.ok_count),   exp_ok);
        check({tag, "_err_count"},  int'(u_if.err_count),  exp_err);
        check({tag, "_drop_count"}, int'(u_if.drop_count), exp_drop);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.rx_data  = 8'h00;
        u_if.rx_valid = 1'b0;

        // Reset state.
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy",    int'(u_if.busy),    0);
        check("rst_msg_ok",  int'(u_if.msg_ok),  0);
        check("rst_msg_err", int'(u_if.msg_err), 0);
        check_stats("rst");
        reset = 1'b0;

        // Full message, one byte every 12 cycles.
        send(hello[0], RES_NONE, 12);
        check("slow_busy_mid", int'(u_if.busy), 1);
        send_msg(1, 12);
        check("slow_busy_after", int'(u_if.busy), 0);
        check_stats("slow");

        // "Hellx": mismatch on 'x' returns to IDLE, nothing dropped.
        send(8'h48, RES_NONE, 1);
        send(8'h65, RES_NONE, 1);
        send(8'h6C, RES_NONE, 1);
        send(8'h6C, RES_NONE, 1);
        send(8'h78, RES_ERR, 3);
        check("hellx_busy", int'(u_if.busy), 0);
        check_stats("hellx");

        // "HelH" resyncs on the second 'H', then the rest back-to-back.
        send(8'h48, RES_NONE, 1);
        send(8'h65, RES_NONE, 1);
        send(8'h6C, RES_NONE, 1);
        send(8'h48, RES_ERR, 1);
        check("resync_busy", int'(u_if.busy), 1);
        send_msg(1, 1);
        repeat (2) @(posedge CLK);
        #1;
        check("resync_busy_after", int'(u_if.busy), 0);
        check_stats("resync");

        // "Hel" then silence: error TO edges after the last byte.
        send(8'h48, RES_NONE, 1);
        send(8'h65, RES_NONE, 1);
        send(8'h6C, RES_NONE, 1);
        note_result(RES_ERR, cyc + TO);
        repeat (TO - 1) @(posedge CLK);
        #1;
        check("timeout_busy_before", int'(u_if.busy), 1);
        repeat (3) @(posedge CLK);
        #1;
        check("timeout_busy_after", int'(u_if.busy), 0);
        check_stats("timeout");

        // A byte landing exactly on the expiry edge keeps the message alive.
        send(8'h48, RES_NONE, 1);
        send(8'h65, RES_NONE, 1);
        send(8'h6C, RES_NONE, TO);
        check("expiry_byte_busy", int'(u_if.busy), 1);
        send_msg(3, 1);
        repeat (2) @(posedge CLK);
        #1;
        check_stats("expiry_byte");

        // Non-start bytes in IDLE are dropped silently.
        send(8'h00, RES_DROP, 1);
        send(8'hFF, RES_DROP, 1);
        send(8'h65, RES_DROP, 2);
        check("drop_busy", int'(u_if.busy), 0);
        check_stats("drop");

        // Reset after 6 correct bytes discards the partial message.
        send_msg(0, 1);
        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < 6; i++) send(hello[i], RES_NONE, 1);
        reset = 1'b1;
        #1;
        exp_ok   = 0;
        exp_err  = 0;
        exp_drop = 0;
        check("midrst_busy", int'(u_if.busy), 0);
        check_stats("midrst_hold");
        @(posedge CLK);
        #1;
        reset = 1'b0;
        send_msg(0, 1);
        repeat (2) @(posedge CLK);
        #1;
        check_stats("midrst_after");

        // drop_count saturates at 255 instead of wrapping.
        for (int i = 0; i < 260; i++) send(8'h00, RES_DROP, 1);
        #1;
        check_stats("drop_sat");

        repeat (3) @(posedge CLK);
        #1;
        check("pending_pulses", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
